// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue
//
// Small FIFO of shift commands that sits in front of a registered barrel
// shifter. Each entry is {direction, amount, data}. The head entry drives the
// shifter directly. Sample_Valid marks the cycle in which the shifter output
// holds the result of the command issued one cycle earlier.
//
// Parameters:
//   DEPTH            number of queue entries (power of two, >= 2)
//
// Ports:
//   Clock            sole clock, rising edge
//   Reset            asynchronous, active-high reset
//   In_Valid         upstream command present
//   In_Ready         queue can accept a command (registered count != DEPTH)
//   In_Direction     0 = left shift, 1 = right shift
//   In_Shift_Amount  shift distance 0-7
//   In_Data          operand
//   Out_Valid        head command presented to shifter (count != 0)
//   Out_Ready        downstream accepts the head command this cycle
//   Direction        head direction, 0 while Out_Valid = 0
//   Shift_Amount     head distance, 0 while Out_Valid = 0
//   Data_In          head operand, 0 while Out_Valid = 0
//   Sample_Valid     shifter result valid (issue delayed by one cycle)
//   Level            registered entry count, only present when the macro
//                    SHIFT_CMD_QUEUE_LEVEL_EN is defined
//
// Configuration macro: SHIFT_CMD_QUEUE_LEVEL_EN

module shift_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic                       In_Direction,
    input  logic [2:0]                 In_Shift_Amount,
    input  logic [7:0]                 In_Data,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic                       Direction,
    output logic [2:0]                 Shift_Amount,
    output logic [7:0]                 Data_In,
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
    output logic                       Sample_Valid,
    output logic [$clog2(DEPTH):0]     Level
`else
    output logic                       Sample_Valid
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [11:0]   head;

    // Handshakes depend only on the registered count, so a pop on a full
    // queue never lets a push through in the same cycle.
    assign In_Ready  = (count != FULL_COUNT);
    assign Out_Valid = (count != '0);
    assign push      = In_Valid && In_Ready;
    assign pop       = Out_Valid && Out_Ready;

    // Storage needs no reset: outputs are gated by Out_Valid, so stale
    // contents are never visible while the queue is empty.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= {In_Direction, In_Shift_Amount, In_Data};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            Sample_Valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Shifter is registered, so its result lines up one cycle after issue.
            Sample_Valid <= pop;
        end
    end

    always_comb begin
        head = 12'h000;
        if (Out_Valid) begin
            head = mem[rd_ptr];
        end
    end

    assign Direction    = head[11];
    assign Shift_Amount = head[10:8];
    assign Data_In      = head[7:0];

`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
    assign Level = count;
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
// tb_shift_cmd_queue
//
// Directed bench for shift_cmd_queue (DEPTH = 4). Commands are written as
// 12-bit {direction, amount, data} constants. A tiny behavioural shifter
// captures the issued head command so the shifted result can be checked
// against hand-computed values when Sample_Valid rises.

module tb_shift_cmd_queue;

    logic        Clock;
    logic        Reset;
    logic        In_Valid;
    logic        In_Ready;
    logic        In_Direction;
    logic [2:0]  In_Shift_Amount;
    logic [7:0]  In_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Direction;
    logic [2:0]  Shift_Amount;
    logic [7:0]  Data_In;
    logic        Sample_Valid;
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
    logic [2:0]  Level;
`endif

    logic [11:0] head;
    logic [7:0]  shifter_out;
    int          vectors;
    int          miscompares;
    logic [11:0] stream_cmds [10];

    shift_cmd_queue #(.DEPTH(4)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .In_Valid        (In_Valid),
        .In_Ready        (In_Ready),
        .In_Direction    (In_Direction),
        .In_Shift_Amount (In_Shift_Amount),
        .In_Data         (In_Data),
        .Out_Valid       (Out_Valid),
        .Out_Ready       (Out_Ready),
        .Direction       (Direction),
        .Shift_Amount    (Shift_Amount),
        .Data_In         (Data_In),
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        .Sample_Valid    (Sample_Valid),
        .Level           (Level)
`else
        .Sample_Valid    (Sample_Valid)
`endif
    );

    assign head = {Direction, Shift_Amount, Data_In};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Stand-in for the downstream registered shifter.
    always @(posedge Clock) begin
        if (Out_Valid && Out_Ready) begin
            shifter_out <= Direction ? (Data_In >> Shift_Amount) : (Data_In << Shift_Amount);
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic valid, input logic [11:0] cmd, input logic ready);
        In_Valid = valid;
        {In_Direction, In_Shift_Amount, In_Data} = cmd;
        Out_Ready = ready;
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        stream_cmds = '{12'h101, 12'hB80, 12'h40F, 12'hAF0, 12'h055,
                        12'hFFF, 12'h233, 12'h9AA, 12'h603, 12'hCC0};
        Reset = 1'b1;
        In_Valid = 1'b0;
        In_Direction = 1'b0;
        In_Shift_Amount = 3'd0;
        In_Data = 8'h00;
        Out_Ready = 1'b0;

        // Reset state, checked before any clock edge.
        #1;
        checkOutput("reset_in_ready", 32'(In_Ready), 32'd1);
        checkOutput("reset_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("reset_head", 32'(head), 32'h000);
        checkOutput("reset_sample_valid", 32'(Sample_Valid), 32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Single push into empty queue, downstream stalled.
        applyStimulus(1'b1, 12'h381, 1'b0);
        checkOutput("first_out_valid", 32'(Out_Valid), 32'd1);
        checkOutput("first_head", 32'(head), 32'h381);
        applyStimulus(1'b0, 12'h000, 1'b0);
        checkOutput("stall_head", 32'(head), 32'h381);
        checkOutput("stall_sample_valid", 32'(Sample_Valid), 32'd0);

        // Fill to DEPTH; a fifth command must be ignored.
        applyStimulus(1'b1, 12'h902, 1'b0);
        applyStimulus(1'b1, 12'h7FF, 1'b0);
        checkOutput("three_in_ready", 32'(In_Ready), 32'd1);
        applyStimulus(1'b1, 12'hDA5, 1'b0);
        checkOutput("full_in_ready", 32'(In_Ready), 32'd0);
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        checkOutput("full_level", 32'(Level), 32'd4);
`endif
        applyStimulus(1'b1, 12'h111, 1'b0);
        checkOutput("full_ignored_head", 32'(head), 32'h381);
        checkOutput("full_ignored_ready", 32'(In_Ready), 32'd0);

        // Pop on a full queue while upstream is valid: no push bypass.
        applyStimulus(1'b1, 12'h111, 1'b1);
        checkOutput("full_pop_in_ready", 32'(In_Ready), 32'd1);
        checkOutput("full_pop_head", 32'(head), 32'h902);
        checkOutput("full_pop_sample", 32'(Sample_Valid), 32'd1);
        checkOutput("full_pop_shift", 32'(shifter_out), 32'h08);
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        checkOutput("full_pop_level", 32'(Level), 32'd3);
`endif

        // Drain: order must be 902, 7FF, DA5 and nothing else.
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("drain1_head", 32'(head), 32'h7FF);
        checkOutput("drain1_shift", 32'(shifter_out), 32'h01);
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("drain2_head", 32'(head), 32'hDA5);
        checkOutput("drain2_shift", 32'(shifter_out), 32'h80);
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("drain3_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("drain3_head", 32'(head), 32'h000);
        checkOutput("drain3_sample", 32'(Sample_Valid), 32'd1);
        checkOutput("drain3_shift", 32'(shifter_out), 32'h05);
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("drain4_sample", 32'(Sample_Valid), 32'd0);

        // Continuous stream: simultaneous push/pop with pointer wrap.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, stream_cmds[i], 1'b1);
            checkOutput($sformatf("stream%0d_head", i), 32'(head), 32'(stream_cmds[i]));
            checkOutput($sformatf("stream%0d_sample", i), 32'(Sample_Valid), (i > 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("stream%0d_in_ready", i), 32'(In_Ready), 32'd1);
            if (i == 4) begin
                checkOutput("stream_shift_f0", 32'(shifter_out), 32'h3C);
            end
        end
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("stream_end_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("stream_end_sample", 32'(Sample_Valid), 32'd1);
        checkOutput("stream_end_shift", 32'(shifter_out), 32'h0C);
        applyStimulus(1'b0, 12'h000, 1'b0);
        checkOutput("stream_idle_sample", 32'(Sample_Valid), 32'd0);

        // Asynchronous reset with two queued and an issue pending.
        applyStimulus(1'b1, 12'h511, 1'b0);
        applyStimulus(1'b1, 12'hB22, 1'b0);
        applyStimulus(1'b1, 12'h777, 1'b0);
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("prereset_sample", 32'(Sample_Valid), 32'd1);
        checkOutput("prereset_head", 32'(head), 32'hB22);
        Out_Ready = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("async_sample", 32'(Sample_Valid), 32'd0);
        checkOutput("async_in_ready", 32'(In_Ready), 32'd1);
        checkOutput("async_head", 32'(head), 32'h000);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        applyStimulus(1'b0, 12'h000, 1'b1);
        checkOutput("post_reset_out_valid", 32'(Out_Valid), 32'd0);
        checkOutput("post_reset_sample", 32'(Sample_Valid), 32'd0);
        applyStimulus(1'b1, 12'h101, 1'b0);
        checkOutput("post_reset_push_head", 32'(head), 32'h101);
        checkOutput("post_reset_push_valid", 32'(Out_Valid), 32'd1);
`ifdef SHIFT_CMD_QUEUE_LEVEL_EN
        checkOutput("post_reset_level", 32'(Level), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
